i2c_cmd_fifo: RTL



---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_fifo_ram.sv | 33 +++
 rtl/i2c_cmd_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command FIFO: entry layout, issue-state encodings
// and the default queue depth.
package i2c_pkg;

  localparam int ENTRY_W       = 16;
  localparam int RW_BIT        = 15;
  localparam int ADDR_HI       = 14;
  localparam int ADDR_LO       = 8;
  localparam int DATA_HI       = 7;
  localparam int DATA_LO       = 0;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    ISS_IDLE = 2'b00,
    ISS_REQ  = 2'b01,
    ISS_BUSY = 2'b10
  } iss_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic       rw,
                                                    input logic [6:0] addr,
                                                    input logic [7:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/i2c_fifo_ram.sv
// Command storage: DEPTH x 16-bit register array, one synchronous write port and
// one asynchronous read port.
module i2c_fifo_ram
  import i2c_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [PTR_W-1:0]   i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [PTR_W-1:0]   i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // Entry write port; contents cleared on reset so no stale command can leak out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {ENTRY_W{1'b0}};
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/i2c_cmd_fifo.sv
// Command queue and issue controller in front of the I2C master FSM.
// Optional sticky overflow flag is built when I2C_CMD_FIFO_OVF_EN is defined.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i2c_clock_in,
  input  logic             i2c_reset_n_in,
  input  logic             wr_en,
  input  logic             wr_rw,
  input  logic [6:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             ovf_clr,
  input  logic             fsm_ready,
  output logic             enable,
  output logic             rw_bit,
  output logic [6:0]       fifo_to_fsm_addr_out,
  output logic [7:0]       fifo_to_fsm_data_out,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level,
  output logic             overflow
);

  localparam int               LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   w_level_nxt;
  logic               r_full;
  logic               r_empty;
  logic               r_overflow;
  iss_state_e         r_state;
  iss_state_e         w_state_nxt;
  logic               r_enable;
  logic               w_enable_nxt;
  logic               w_load;
  logic               w_pop;
  logic               w_push;
  logic               r_rw;
  logic [6:0]         r_addr;
  logic [7:0]         r_data;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  // A push is judged against the registered full flag, so a pop on the same edge cannot rescue it
  assign w_push     = wr_en && !r_full;
  assign w_wr_entry = pack_entry(wr_rw, wr_addr, wr_data);

  i2c_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk     (i2c_clock_in),
    .i_rst_n   (i2c_reset_n_in),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  // Occupancy update for push/pop combinations
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Pointers, occupancy and the registered full/empty flags
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_MAX);
      r_empty <= (w_level_nxt == LVL_ZERO);
    end
  end

  // Issue FSM: the head is popped only once the master has visibly left idle
  always_comb begin
    w_state_nxt  = r_state;
    w_enable_nxt = r_enable;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ISS_IDLE: begin
        if (!r_empty && fsm_ready) begin
          w_state_nxt  = ISS_REQ;
          w_enable_nxt = 1'b1;
          w_load       = 1'b1;
        end else begin
          w_enable_nxt = 1'b0;
        end
      end
      ISS_REQ: begin
        if (!fsm_ready) begin
          w_state_nxt  = ISS_BUSY;
          w_enable_nxt = 1'b0;
          w_pop        = 1'b1;
        end else begin
          w_enable_nxt = 1'b1;
        end
      end
      ISS_BUSY: begin
        w_enable_nxt = 1'b0;
        if (fsm_ready) begin
          w_state_nxt = ISS_IDLE;
        end else begin
          w_state_nxt = ISS_BUSY;
        end
      end
      default: begin
        w_state_nxt  = ISS_IDLE;
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  // Issue state and command output registers
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      r_state  <= ISS_IDLE;
      r_enable <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= 7'h00;
      r_data   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_enable <= w_enable_nxt;
      if (w_load) begin
        r_rw   <= w_head[RW_BIT];
        r_addr <= w_head[ADDR_HI:ADDR_LO];
        r_data <= w_head[DATA_HI:DATA_LO];
      end
    end
  end

`ifdef I2C_CMD_FIFO_OVF_EN
  // Sticky overflow: a dropped push beats a simultaneous clear
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      r_overflow <= 1'b0;
    end else if (wr_en && r_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end
`else
  // Feature disabled: the flag never leaves its reset value of 0
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
    if (!i2c_reset_n_in) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow & ~ovf_clr;
    end
  end
`endif

  assign enable               = r_enable;
  assign rw_bit               = r_rw;
  assign fifo_to_fsm_addr_out = r_addr;
  assign fifo_to_fsm_data_out = r_data;
  assign full                 = r_full;
  assign empty                = r_empty;
  assign level                = r_level;
  assign overflow             = r_overflow;

endmodule
